hazard_controller: RTL

// - Sequences the 5-stage RISC-V pipeline around the control unit: detects load-use hazards, flushes wrong-path

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_if.sv | 39 +++
 rtl/hazard_controller.sv | 105 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_t : controller FSM states (RUN, MEMWAIT)
//   REG_X0  : register index of the hard-wired zero register
package hazard_pkg;

    typedef enum logic {
        RUN,
        MEMWAIT
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_if.sv
// Pipeline <-> hazard controller signal bundle.
//   master : pipeline side, drives hazard sources, receives controls
//   slave  : hazard controller, receives hazard sources, drives controls
// Hazard sources: id_rs1, id_rs2, idex_rd, idex_memread, exmem_branch,
//                 exmem_zero, exmem_memacc, dmem_ready
// Controls:       stall, pc_write, ifid_write, ifid_flush, idex_flush,
//                 exmem_flush, freeze
interface hazard_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] idex_rd;
    logic       idex_memread;
    logic       exmem_branch;
    logic       exmem_zero;
    logic       exmem_memacc;
    logic       dmem_ready;

    logic       stall;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic       freeze;

    modport master (
        output id_rs1, id_rs2, idex_rd, idex_memread,
               exmem_branch, exmem_zero, exmem_memacc, dmem_ready,
        input  stall, pc_write, ifid_write, ifid_flush,
               idex_flush, exmem_flush, freeze
    );

    modport slave (
        input  id_rs1, id_rs2, idex_rd, idex_memread,
               exmem_branch, exmem_zero, exmem_memacc, dmem_ready,
        output stall, pc_write, ifid_write, ifid_flush,
               idex_flush, exmem_flush, freeze
    );
endinterface

// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage RISC-V pipeline.
// Detects load-use hazards (one bubble), flushes wrong-path instructions on
// a taken beq, and freezes the pipeline while a data-memory access waits.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   hz           : hazard_if.slave (hazard sources in, pipeline controls out)
//   mem_timeout  : sticky, a memory wait lasted TIMEOUT cycles
//   stall_cnt    : saturating count of bubble + freeze cycles
//   flush_cnt    : saturating count of taken-branch flushes
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    hazard_if.slave          hz,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    state_t              state, state_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                lu, bt, hold;

    assign lu = hz.idex_memread && (hz.idex_rd != REG_X0) &&
                ((hz.idex_rd == hz.id_rs1) || (hz.idex_rd == hz.id_rs2));
    assign bt = hz.exmem_branch && hz.exmem_zero;
    // Freeze starts in the same cycle the stalled access is seen in RUN.
    assign hold = (state == MEMWAIT) || (hz.exmem_memacc && !hz.dmem_ready);

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next     = state;
        hz.stall       = 1'b0;
        hz.pc_write    = 1'b1;
        hz.ifid_write  = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_flush  = 1'b0;
        hz.exmem_flush = 1'b0;
        hz.freeze      = 1'b0;

        if (!reset) begin
            case (state)
                RUN:     if (hz.exmem_memacc && !hz.dmem_ready) state_next = MEMWAIT;
                MEMWAIT: if (hz.dmem_ready) state_next = RUN;
                default: state_next = RUN;
            endcase

            if (hold) begin
                hz.freeze     = 1'b1;
                hz.pc_write   = 1'b0;
                hz.ifid_write = 1'b0;
            end else if (bt) begin
                // Any coincident load-use is on the wrong path and is dropped.
                hz.ifid_flush  = 1'b1;
                hz.idex_flush  = 1'b1;
                hz.exmem_flush = 1'b1;
            end else if (lu) begin
                hz.stall      = 1'b1;
                hz.pc_write   = 1'b0;
                hz.ifid_write = 1'b0;
            end
        end
    end

    // wait_cnt holds the number of MEMWAIT cycles already completed; clearing
    // it throughout RUN is equivalent to clearing it on entry.
    always_ff @(posedge clk) begin
        if (reset || state == RUN)
            wait_cnt <= '0;
        else if (wait_cnt != WAIT_W'(TIMEOUT))
            wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            mem_timeout <= 1'b0;
        else if (state == MEMWAIT && wait_cnt >= WAIT_W'(TIMEOUT - 1))
            mem_timeout <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if ((hz.stall || hz.freeze) && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            flush_cnt <= '0;
        else if (hz.exmem_flush && flush_cnt != '1)
            flush_cnt <= flush_cnt + CNT_W'(1);
    end

endmodule
